// File: rtl/music_player.sv
// music_player: four-track square-wave note player with volume and mute control.
// Samples are +/-(volume << 11), registered, and identical on both channels.
module music_player #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BEAT_HZ   = 8,
    parameter int unsigned SHEET_LEN = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vol_up,
    input  logic                         vol_down,
    input  logic                         mute,
    input  logic [1:0]                   track,
    output logic [15:0]                  audio_in_left,
    output logic [15:0]                  audio_in_right,
    output logic [2:0]                   volume,
    output logic [$clog2(SHEET_LEN)-1:0] note_idx
);

    localparam int unsigned     IdxW    = $clog2(SHEET_LEN);
    localparam int unsigned     BeatCyc = CLK_HZ / BEAT_HZ;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(SHEET_LEN - 1);
    localparam longint unsigned ClkX50  = 64'(CLK_HZ) * 64'd50;

    // One 16-note phrase per track, entry i in nibble i; the game-over phrase ends on rests.
    localparam logic [63:0] SheetMenu = 64'h0153_0C0A_058A_0C0A;
    localparam logic [63:0] SheetPlay = 64'h0356_8ACC_A865_5311;
    localparam logic [63:0] SheetOver = 64'h0000_1133_0155_88CC;

    function automatic logic [3:0] sheet_rom(input logic [1:0] trk, input logic [IdxW-1:0] idx);
        logic [3:0] pos;
        pos = 4'(idx);
        case (trk)
            2'd1:    sheet_rom = SheetMenu[{pos, 2'b00} +: 4];
            2'd2:    sheet_rom = SheetPlay[{pos, 2'b00} +: 4];
            2'd3:    sheet_rom = SheetOver[{pos, 2'b00} +: 4];
            default: sheet_rom = 4'd0;
        endcase
    endfunction

    // Half period = CLK_HZ / (2 f), with f given in centi-hertz to keep C4..B4 exact enough.
    function automatic logic [31:0] half_period(input logic [3:0] code);
        case (code)
            4'd1:    half_period = 32'(ClkX50 / 64'd26163);
            4'd2:    half_period = 32'(ClkX50 / 64'd27718);
            4'd3:    half_period = 32'(ClkX50 / 64'd29366);
            4'd4:    half_period = 32'(ClkX50 / 64'd31113);
            4'd5:    half_period = 32'(ClkX50 / 64'd32963);
            4'd6:    half_period = 32'(ClkX50 / 64'd34923);
            4'd7:    half_period = 32'(ClkX50 / 64'd36999);
            4'd8:    half_period = 32'(ClkX50 / 64'd39200);
            4'd9:    half_period = 32'(ClkX50 / 64'd41530);
            4'd10:   half_period = 32'(ClkX50 / 64'd44000);
            4'd11:   half_period = 32'(ClkX50 / 64'd46616);
            4'd12:   half_period = 32'(ClkX50 / 64'd49388);
            default: half_period = 32'd0;
        endcase
    endfunction

    logic [1:0]      r_track;
    logic [31:0]     r_beat_cnt, w_beat_cnt;
    logic [IdxW-1:0] r_note_idx, w_note_idx;
    logic [31:0]     r_tone_cnt, w_tone_cnt;
    logic            r_sq, w_sq;
    logic            r_done, w_done;
    logic [2:0]      r_volume, w_volume;
    logic [15:0]     r_audio, w_audio;
    logic [3:0]      w_code;
    logic [31:0]     w_hp;
    logic [15:0]     w_amp;
    logic            w_silent;

    assign w_code = sheet_rom(r_track, r_note_idx);
    assign w_hp   = half_period(w_code);

    always_comb begin
        w_beat_cnt = r_beat_cnt + 32'd1;
        w_note_idx = r_note_idx;
        w_done     = r_done;
        w_tone_cnt = r_tone_cnt + 32'd1;
        w_sq       = r_sq;
        if (w_hp == 32'd0) begin
            w_tone_cnt = 32'd0;
            w_sq       = 1'b1;
        end else if (r_tone_cnt >= w_hp - 32'd1) begin
            w_tone_cnt = 32'd0;
            w_sq       = ~r_sq;
        end
        if (r_beat_cnt >= 32'(BeatCyc - 1)) begin
            w_beat_cnt = 32'd0;
            if (r_track == 2'd3 && r_note_idx == LastIdx) begin
                w_done = 1'b1;
            end else begin
                w_note_idx = r_note_idx + IdxW'(1);
                // A repeated note keeps its phase; a new note starts high from zero.
                if (sheet_rom(r_track, w_note_idx) != w_code) begin
                    w_tone_cnt = 32'd0;
                    w_sq       = 1'b1;
                end
            end
        end
        if (track != r_track) begin
            w_beat_cnt = 32'd0;
            w_note_idx = '0;
            w_tone_cnt = 32'd0;
            w_sq       = 1'b1;
            w_done     = 1'b0;
        end
    end

    always_comb begin
        w_volume = r_volume;
        if (vol_up && !vol_down && r_volume < 3'd5) begin
            w_volume = r_volume + 3'd1;
        end else if (vol_down && !vol_up && r_volume > 3'd1) begin
            w_volume = r_volume - 3'd1;
        end
        w_amp    = {2'b00, r_volume, 11'd0};
        w_silent = (w_code == 4'd0) || mute || (r_track == 2'd0) || r_done;
        w_audio  = w_silent ? 16'd0 : (r_sq ? w_amp : 16'd0 - w_amp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_track    <= track;
            r_beat_cnt <= '0;
            r_note_idx <= '0;
            r_tone_cnt <= '0;
            r_sq       <= 1'b1;
            r_done     <= 1'b0;
            r_volume   <= 3'd3;
            r_audio    <= '0;
        end else begin
            r_track    <= track;
            r_beat_cnt <= w_beat_cnt;
            r_note_idx <= w_note_idx;
            r_tone_cnt <= w_tone_cnt;
            r_sq       <= w_sq;
            r_done     <= w_done;
            r_volume   <= w_volume;
            r_audio    <= w_audio;
        end
    end

    assign audio_in_left  = r_audio;
    assign audio_in_right = r_audio;
    assign volume         = r_volume;
    assign note_idx       = r_note_idx;

endmodule
